led_pwm_core: RTL and testbench
===============================

LED_PWM_CORE -- requirements
Module: led_pwm_core

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 dbw  input  8  bus write data.
REQ-005 dbr  output 8  bus read data, combinational from addr.
REQ-006 addr input  4  register address.
REQ-007 we   input  1  write strobe; one write per cycle where high.
REQ-008 pwm_red, pwm_green, pwm_blue  output 1 each  registered PWM outputs.

Function
REQ-009 Register map SHALL be:
- 0 DUTYR, 1 DUTYG, 2 DUTYB: 8-bit duty.
- 3 PRESCL: prescale[7:0].
- 4 PRESCH: prescale[9:8] in bits[1:0]; bits[7:2] read 0.
- 5 CTRL: bit7 EN, bit6 POL (1 = active-low), bit0 BLINK; other bits read 0.
- 6 ONTIME, 7 OFFTIME: 8-bit frame counts.
REQ-010 Writes to addr 8-15 SHALL be ignored; reads of addr 8-15 SHALL return 0x00.
REQ-011 dbr SHALL return the last written (staged) value, masked per REQ-009.
REQ-012 Prescaler SHALL be a 10-bit counter:
- tick asserts for one cycle when counter >= prescale;
- the counter then returns to 0, otherwise increments.
- Tick period is prescale+1 cycles; prescale=0 ticks every cycle.
REQ-013 PWM counter SHALL be 8-bit, increment on tick, and wrap 255->0.
- A frame is 256 ticks.
- Frame end is a tick with PWM counter = 255.
REQ-014 Each channel SHALL use an active duty shadow register, loaded from DUTYx only at frame end.
- Mid-frame duty writes SHALL NOT affect the current frame.
REQ-015 Channel raw-on SHALL equal (PWM counter < active duty).
- duty 0 gives always off; duty 255 gives on 255 of 256 ticks.
REQ-016 Blink state machine SHALL have states ON and OFF plus an 8-bit frame counter.
- Active only when BLINK=1.
- In ON: after ONTIME completed frames, go to OFF and clear the counter.
- In OFF: after OFFTIME frames, go to ON and clear the counter.
REQ-017 Blink boundary cases:
- ONTIME=0 with BLINK=1: channels always inactive.
- OFFTIME=0 with BLINK=1: never remain in OFF.
- BLINK=0: state forced to ON, frame counter held at 0.
REQ-018 Channel active SHALL equal EN and raw-on and (state==ON).
REQ-019 Output value SHALL be active XOR POL, registered; one cycle latency from counter state to pin.
REQ-020 When EN=0:
- prescaler, PWM counter, frame counter and blink state SHALL be held at 0/ON;
- outputs SHALL sit at the inactive level (POL).
REQ-021 On the EN 0->1 edge, shadow duties SHALL load immediately from DUTYx.
- The first frame starts at PWM count 0.
REQ-022 A prescale write that leaves the counter above the new value SHALL produce a tick on the next cycle (>= compare); no lock-up.
REQ-023 A write to a register and a frame-end tick in the same cycle: the shadow SHALL take the pre-write value; the new value applies next frame.

Reset
REQ-024 rst SHALL asynchronously clear:
- all registers, shadows, counters and the frame counter (to 0);
- blink state (to ON);
- pwm_red, pwm_green and pwm_blue (to 0).
REQ-025 Release of rst SHALL be sampled synchronously; reset asserted mid-frame SHALL abort immediately with no residual output pulse.

Verification
REQ-026 Setup: prescale=0, DUTYR=64, CTRL=0x80, sampled over 512 cycles.
- Response: pwm_red high exactly 64 of each 256 cycles, rising 1 cycle after count 0.
- pwm_green and pwm_blue stay 0.
REQ-027 Setup: DUTYG=128 running; write DUTYG=32 at PWM count 10.
- Response: current frame high 128 ticks; next frame high 32 ticks.
REQ-028 Setup: CTRL=0xC0 (POL set), DUTYB=0.
- Response: pwm_blue constant 1.
- CTRL=0x40 also gives constant 1, with counters held at 0.
REQ-029 Setup: CTRL=0x81, ONTIME=2, OFFTIME=3, DUTYR=255, prescale=0.
- Response: red pulses for 2 frames, 0 for 3 frames, repeating.
- ONTIME=0 gives red constant 0.
REQ-030 Setup: prescale=1023 with counter at 900, then write PRESCH=0, PRESCL=5.
- Response: tick on the following cycle, then every 6 cycles.
- Reads of addr 4 return 0x00; addr 9 reads 0x00.
REQ-031 Setup: assert rst mid-pulse with DUTYR=200.
- Response: pwm_red drops to 0 in the same cycle without waiting for a clock edge.
- All reads return 0x00 after reset.

Source files
------------

// File: rtl/led_pwm_core.sv
// Three-channel LED PWM core with bus-mapped duty, prescale, polarity and frame-based blink.
// Latency: one cycle from PWM counter state to output pin; register reads are combinational.
// Backpressure: none; a write is accepted on every cycle where we is high.
module led_pwm_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    input  logic [3:0] addr,
    input  logic       we,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue
);

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } blink_t;

    // Staged bus registers
    logic [7:0] duty_r;
    logic [7:0] duty_g;
    logic [7:0] duty_b;
    logic [9:0] prescale;
    logic       en;
    logic       pol;
    logic       blink;
    logic [7:0] ontime;
    logic [7:0] offtime;

    // Timing state
    logic [9:0] pcnt;
    logic [7:0] cnt;
    logic [7:0] shadow_r;
    logic [7:0] shadow_g;
    logic [7:0] shadow_b;
    blink_t     state;
    blink_t     state_nxt;
    logic [7:0] fcnt;
    logic [7:0] fcnt_nxt;
    logic [8:0] fcnt_inc;

    logic       tick;
    logic       frame_end;
    logic       blink_on;
    logic       act_r;
    logic       act_g;
    logic       act_b;

    // Bus register writes; addresses 8-15 fall through the case and are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r   <= 8'h00;
            duty_g   <= 8'h00;
            duty_b   <= 8'h00;
            prescale <= 10'h000;
            en       <= 1'b0;
            pol      <= 1'b0;
            blink    <= 1'b0;
            ontime   <= 8'h00;
            offtime  <= 8'h00;
        end else if (we) begin
            case (addr)
                4'd0: duty_r          <= dbw;
                4'd1: duty_g          <= dbw;
                4'd2: duty_b          <= dbw;
                4'd3: prescale[7:0]   <= dbw;
                4'd4: prescale[9:8]   <= dbw[1:0];
                4'd5: begin
                    en    <= dbw[7];
                    pol   <= dbw[6];
                    blink <= dbw[0];
                end
                4'd6: ontime          <= dbw;
                4'd7: offtime         <= dbw;
                default: ;
            endcase
        end
    end

    // Combinational read-back of the staged registers, unused bits read as zero
    always_comb begin
        dbr = 8'h00;
        case (addr)
            4'd0: dbr = duty_r;
            4'd1: dbr = duty_g;
            4'd2: dbr = duty_b;
            4'd3: dbr = prescale[7:0];
            4'd4: dbr = {6'b000000, prescale[9:8]};
            4'd5: dbr = {en, pol, 5'b00000, blink};
            4'd6: dbr = ontime;
            4'd7: dbr = offtime;
            default: dbr = 8'h00;
        endcase
    end

    // >= compare so that shrinking the prescale below the running count still ticks next cycle
    assign tick      = en && (pcnt >= prescale);
    assign frame_end = tick && (cnt == 8'hFF);

    // Prescaler and PWM counter, both parked at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= 10'h000;
            cnt  <= 8'h00;
        end else if (!en) begin
            pcnt <= 10'h000;
            cnt  <= 8'h00;
        end else if (tick) begin
            pcnt <= 10'h000;
            cnt  <= cnt + 8'd1;
        end else begin
            pcnt <= pcnt + 10'd1;
        end
    end

    // Shadows follow the staged duties while disabled (so enabling starts with current duties)
    // and otherwise reload only at frame end, taking the pre-write value on a colliding write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 8'h00;
            shadow_g <= 8'h00;
            shadow_b <= 8'h00;
        end else if (!en || frame_end) begin
            shadow_r <= duty_r;
            shadow_g <= duty_g;
            shadow_b <= duty_b;
        end
    end

    // Blink state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ON;
            fcnt  <= 8'h00;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Blink next-state: count completed frames in each phase; a zero OFFTIME never leaves us in OFF
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        fcnt_inc  = {1'b0, fcnt} + 9'd1;
        if (!en || !blink) begin
            state_nxt = ST_ON;
            fcnt_nxt  = 8'h00;
        end else begin
            case (state)
                ST_ON: begin
                    if (frame_end) begin
                        if (fcnt_inc >= {1'b0, ontime}) begin
                            fcnt_nxt = 8'h00;
                            if (offtime != 8'h00) begin
                                state_nxt = ST_OFF;
                            end
                        end else begin
                            fcnt_nxt = fcnt_inc[7:0];
                        end
                    end
                end
                ST_OFF: begin
                    if (offtime == 8'h00) begin
                        state_nxt = ST_ON;
                        fcnt_nxt  = 8'h00;
                    end else if (frame_end) begin
                        if (fcnt_inc >= {1'b0, offtime}) begin
                            state_nxt = ST_ON;
                            fcnt_nxt  = 8'h00;
                        end else begin
                            fcnt_nxt = fcnt_inc[7:0];
                        end
                    end
                end
                default: begin
                    state_nxt = ST_ON;
                    fcnt_nxt  = 8'h00;
                end
            endcase
        end
    end

    // A zero ONTIME keeps the channels dark whatever phase the state machine is in
    assign blink_on = !blink || ((ontime != 8'h00) && (state == ST_ON));
    assign act_r    = en && blink_on && (cnt < shadow_r);
    assign act_g    = en && blink_on && (cnt < shadow_g);
    assign act_b    = en && blink_on && (cnt < shadow_b);

    // Registered outputs with polarity applied; reset forces them low immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            pwm_red   <= act_r ^ pol;
            pwm_green <= act_g ^ pol;
            pwm_blue  <= act_b ^ pol;
        end
    end

endmodule

// File: tb/tb_led_pwm_core.sv
// Bench for led_pwm_core: register table, directed frame sequences and random traffic
// against a tick/frame-count reference model. Inputs change on the falling edge and
// outputs are sampled on the following falling edge.
module tb_led_pwm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dbw;
    logic [7:0] dbr;
    logic [3:0] addr;
    logic       we;
    logic       pwm_red;
    logic       pwm_green;
    logic       pwm_blue;

    led_pwm_core dut (
        .clk       (clk),
        .rst       (rst),
        .dbw       (dbw),
        .dbr       (dbr),
        .addr      (addr),
        .we        (we),
        .pwm_red   (pwm_red),
        .pwm_green (pwm_green),
        .pwm_blue  (pwm_blue)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_reg[8];
    logic [7:0] m_shadow[3];
    int         m_ps;
    int         m_ticks;     // ticks since enable: PWM count = ticks%256, frame = ticks/256
    int         m_bbase;     // frame index at which blink counting started
    logic [2:0] m_exp;       // {blue, green, red}
    logic [2:0] pwm_s;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        return a[3] ? 8'h00 : m_reg[a[2:0]];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        for (int c = 0; c < 3; c++) m_shadow[c] = 8'h00;
        m_ps = 0; m_ticks = 0; m_bbase = 0; m_exp = 3'b000;
    endtask

    task automatic m_step(input bit w, input logic [3:0] a, input logic [7:0] d);
        logic en, pol, bl;
        int   presc, cnt, frame, on, off;
        bit   bon;
        en    = m_reg[5][7];
        pol   = m_reg[5][6];
        bl    = m_reg[5][0];
        presc = {m_reg[4][1:0], m_reg[3]};
        if (en) begin
            cnt   = m_ticks % 256;
            frame = m_ticks / 256;
            on    = m_reg[6];
            off   = m_reg[7];
            if (!bl)           bon = 1'b1;
            else if (on == 0)  bon = 1'b0;
            else if (off == 0) bon = 1'b1;
            else               bon = (((frame - m_bbase) % (on + off)) < on);
            for (int c = 0; c < 3; c++) m_exp[c] = ((cnt < m_shadow[c]) && bon) ^ pol;
            if (m_ps >= presc) begin
                if (cnt == 255) for (int c = 0; c < 3; c++) m_shadow[c] = m_reg[c];
                m_ticks++;
                m_ps = 0;
            end else begin
                m_ps++;
            end
            if (!bl) m_bbase = m_ticks / 256;
        end else begin
            m_exp   = {3{pol}};
            m_ps    = 0;
            m_ticks = 0;
            m_bbase = 0;
            for (int c = 0; c < 3; c++) m_shadow[c] = m_reg[c];
        end
        if (w && !a[3]) begin
            if (a == 4'd4)      m_reg[4] = d & 8'h03;
            else if (a == 4'd5) m_reg[5] = d & 8'hC1;
            else                m_reg[a[2:0]] = d;
        end
    endtask

    // One clock cycle: drive, check read data, advance model, check pins
    task automatic step(input bit w, input logic [3:0] a, input logic [7:0] d);
        we = w; addr = a; dbw = d;
        #1;
        chk($sformatf("dbr addr%0d", a), dbr, m_read(a));
        m_step(w, a, d);
        @(negedge clk);
        pwm_s = {pwm_blue, pwm_green, pwm_red};
        chk("pwm pins", pwm_s, m_exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b1, a, d);
    endtask

    task automatic idle();
        step(1'b0, 4'($urandom_range(0, 15)), 8'h00);
    endtask

    typedef struct {
        bit         w;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   cr, cg, cb;
    logic [3:0] ra;
    logic [7:0] rd;

    initial begin
        rst = 1'b1; we = 1'b0; addr = 4'd0; dbw = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset pins", {pwm_blue, pwm_green, pwm_red}, 0);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            chk($sformatf("reset dbr addr%0d", a), dbr, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Register map table
        tbl = '{
            '{1, 4'd0, 8'h11, 8'h00}, '{1, 4'd1, 8'h22, 8'h00}, '{1, 4'd2, 8'h33, 8'h00},
            '{1, 4'd3, 8'hAB, 8'h00}, '{1, 4'd4, 8'hFF, 8'h00}, '{1, 4'd5, 8'h3F, 8'h00},
            '{1, 4'd6, 8'h07, 8'h00}, '{1, 4'd7, 8'h09, 8'h00}, '{1, 4'd9, 8'h5A, 8'h00},
            '{1, 4'd15, 8'hFF, 8'h00},
            '{0, 4'd0, 8'h00, 8'h11}, '{0, 4'd1, 8'h00, 8'h22}, '{0, 4'd2, 8'h00, 8'h33},
            '{0, 4'd3, 8'h00, 8'hAB}, '{0, 4'd4, 8'h00, 8'h03}, '{0, 4'd5, 8'h00, 8'h01},
            '{0, 4'd6, 8'h00, 8'h07}, '{0, 4'd7, 8'h00, 8'h09}, '{0, 4'd8, 8'h00, 8'h00},
            '{0, 4'd9, 8'h00, 8'h00}, '{0, 4'd15, 8'h00, 8'h00},
            '{1, 4'd4, 8'hFC, 8'h00}, '{0, 4'd4, 8'h00, 8'h00},
            '{1, 4'd5, 8'h00, 8'h00}, '{0, 4'd5, 8'h00, 8'h00}
        };
        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].a, tbl[i].d);
            if (!tbl[i].w) chk($sformatf("table read addr%0d", tbl[i].a), dbr, tbl[i].exp);
        end
        wr(4'd3, 8'h00); wr(4'd4, 8'h00); wr(4'd6, 8'h00); wr(4'd7, 8'h00);
        wr(4'd0, 8'h00); wr(4'd1, 8'h00); wr(4'd2, 8'h00);

        // Basic duty: red 64/256, first high sample is the cycle at count 0
        wr(4'd0, 8'd64);
        wr(4'd5, 8'h80);
        chk("enable edge red", pwm_s[0], 0);
        cr = 0; cg = 0; cb = 0;
        for (int j = 1; j <= 512; j++) begin
            idle();
            if (j == 1)  chk("red high at count 0", pwm_s[0], 1);
            if (j == 64) chk("red high at count 63", pwm_s[0], 1);
            if (j == 65) chk("red low at count 64", pwm_s[0], 0);
            cr += pwm_s[0]; cg += pwm_s[1]; cb += pwm_s[2];
        end
        chk("red high count 512", cr, 128);
        chk("green high count", cg, 0);
        chk("blue high count", cb, 0);
        wr(4'd5, 8'h00);

        // Mid-frame duty write waits for the frame boundary
        wr(4'd1, 8'd128);
        wr(4'd5, 8'h80);
        cg = 0;
        for (int j = 1; j <= 512; j++) begin
            if (j == 11) wr(4'd1, 8'd32);
            else idle();
            if (j == 256) begin
                chk("green frame0 count", cg + pwm_s[1], 128);
                cg = 0;
            end else begin
                cg += pwm_s[1];
            end
        end
        chk("green frame1 count", cg, 32);
        wr(4'd5, 8'h00); wr(4'd0, 8'h00); wr(4'd1, 8'h00);

        // Active-low polarity with zero duty, enabled then disabled
        wr(4'd2, 8'h00);
        wr(4'd5, 8'hC0);
        cb = 0;
        for (int j = 0; j < 300; j++) begin idle(); cb += pwm_s[2]; end
        chk("blue pol enabled", cb, 300);
        wr(4'd5, 8'h40);
        cb = 0; cr = 0;
        for (int j = 0; j < 100; j++) begin idle(); cb += pwm_s[2]; cr += pwm_s[0]; end
        chk("blue pol disabled", cb, 100);
        chk("red pol disabled", cr, 100);
        wr(4'd5, 8'h00);

        // Blink 2 on / 3 off
        wr(4'd0, 8'd255); wr(4'd6, 8'd2); wr(4'd7, 8'd3);
        wr(4'd5, 8'h81);
        for (int k = 0; k < 10; k++) begin
            cr = 0;
            for (int j = 0; j < 256; j++) begin idle(); cr += pwm_s[0]; end
            chk($sformatf("blink frame %0d", k), cr, ((k % 5) < 2) ? 255 : 0);
        end
        wr(4'd5, 8'h00); wr(4'd6, 8'd0); wr(4'd5, 8'h81);
        cr = 0;
        for (int j = 0; j < 600; j++) begin idle(); cr += pwm_s[0]; end
        chk("ontime zero red", cr, 0);
        wr(4'd5, 8'h00); wr(4'd7, 8'd0);

        // Prescale shrink below a running count
        wr(4'd0, 8'd1); wr(4'd3, 8'hFF); wr(4'd4, 8'h03);
        wr(4'd5, 8'h80);
        cr = 0;
        for (int j = 1; j <= 900; j++) begin idle(); cr += pwm_s[0]; end
        chk("red held at count 0", cr, 900);
        wr(4'd4, 8'h00);
        idle();
        chk("red before shrink tick", pwm_s[0], 1);
        wr(4'd3, 8'd5);
        chk("red after shrink tick", pwm_s[0], 0);
        step(1'b0, 4'd4, 8'h00); chk("read addr4", dbr, 0);
        step(1'b1, 4'd9, 8'hAA);
        step(1'b0, 4'd9, 8'h00); chk("read addr9", dbr, 0);
        repeat (200) idle();
        wr(4'd5, 8'h00);

        // Asynchronous reset mid-pulse
        wr(4'd0, 8'd200); wr(4'd3, 8'h00); wr(4'd4, 8'h00);
        wr(4'd5, 8'h80);
        repeat (50) idle();
        chk("red before reset", pwm_s[0], 1);
        #2 rst = 1'b1;
        #1 chk("red async drop", pwm_red, 0);
        m_reset();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            chk($sformatf("post-reset dbr addr%0d", a), dbr, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model
        for (int ep = 0; ep < 4; ep++) begin
            wr(4'd5, 8'h00);
            wr(4'd6, 8'($urandom_range(0, 3)));
            wr(4'd7, 8'($urandom_range(0, 3)));
            wr(4'd3, 8'($urandom_range(0, 1)));
            wr(4'd4, 8'h00);
            wr(4'd5, 8'h80 | 8'($urandom_range(0, 1) << 6) |
                     ((ep % 2 == 0) ? 8'h01 : 8'($urandom_range(0, 1))));
            for (int j = 0; j < 3000; j++) begin
                if ($urandom_range(0, 9) < 3) begin
                    ra = 4'($urandom_range(0, 15));
                    if (ra >= 4'd5 && ra <= 4'd7) ra = ra - 4'd5;
                    rd = 8'($urandom);
                    if (ra == 4'd3) rd = 8'($urandom_range(0, 1));
                    if (ra == 4'd4) rd = rd & 8'hFC;
                    wr(ra, rd);
                end else begin
                    idle();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
